msx_mouse_reader: RTL and testbench
===================================

# msx_mouse_reader

Host-side reader for the MSX strobe-clocked mouse protocol: toggles the port strobe four times and reassembles the returned nibbles into signed X/Y deltas and button states. It is the initiating end of the protocol that our joystick-port mouse responder answers. It lets the FPGA side, such as a debug/OSD path or a test harness, poll a mouse on a joystick port without the Z80 BIOS. It sits between the joystick port pins and any consumer in the `clk_sys` domain.

## Interface
Parameters:
- `DELAY`, default 64: settle cycles between a strobe edge and the nibble sample; legal range 1..16383.
- `RESYNC`, default 131072: idle cycles held after reset before the first frame; must exceed the responder's 100000-cycle nibble timeout.

Ports:
- `clk_sys`  in  1  system clock; sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to read one frame; accepted only in IDLE.
- `joy_in`  in  6  port pins, active-low as seen at the port: [3:0] data nibble, [5:4] buttons 2/1.
- `stra`  out  1  strobe line driven to the port.
- `busy`  out  1  high from reset through RESYNC and during any frame.
- `dx`  out  8  signed X delta of the last frame; positive = left, per MSX convention.
- `dy`  out  8  signed Y delta of the last frame; positive = up.
- `btn`  out  2  buttons of the last frame, active-high: [0] = button 1 (pin 5), [1] = button 2 (pin 4).
- `valid`  out  1  one-cycle pulse when `dx`/`dy`/`btn` update.

## Operation
- States: RESYNC, IDLE, TOGGLE, WAIT, DONE.
- RESYNC: entered on reset. 17-bit counter counts RESYNC cycles, then the block moves to IDLE. `start` is ignored and not queued.
- IDLE: `busy`=0. When `start`=1, go to TOGGLE and clear the nibble index to 0.
- TOGGLE: `stra` <= ~`stra`; settle counter <= DELAY-1; go to WAIT.
- WAIT: decrement the counter while it is nonzero. When it is 0, sample `joy_in[3:0]` into nibble[idx].
  - If idx=3, also latch ~`joy_in[5:4]` and go to DONE.
  - Otherwise increment idx and go to TOGGLE.
- DONE: `dx` <= {nib0,nib1}; `dy` <= {nib2,nib3}. Nibble 0 is the high half. `btn` <= the latched buttons. `valid`=1 for this cycle. Go to IDLE.
- The data nibble is taken as the raw pin level; the responder already drives true bit values. Only the buttons are inverted.
- The strobe level persists between frames; each frame issues exactly four edges. No strobe edge occurs outside TOGGLE, except the reset edge.
- `dx`, `dy` and `btn` hold their value between frames; they change only in DONE.
- Reset mid-frame: the frame is aborted, no `valid` is issued, and outputs return to their reset values. The RESYNC wait lets the responder time out back to nibble 0.
- `start` while `busy`=1 is dropped.

## Timing
- Reset values: `stra`=0, `busy`=1, `dx`=0, `dy`=0, `btn`=0, `valid`=0; state RESYNC.
- `busy` falls RESYNC cycles after `reset` deasserts.
- `start` is sampled at cycle 0, with state IDLE.
- The first `stra` edge appears at the end of cycle 1.
- Each nibble period is DELAY+1 cycles. The nibble is sampled DELAY cycles after its strobe edge becomes visible.
- The fourth sample is taken at the edge ending cycle 4·(DELAY+1).
- `valid` is high during cycle 4·(DELAY+1)+1, and the outputs are updated in that same cycle.
- `busy` is high from cycle 1 through the `valid` cycle, and low the next cycle. The earliest back-to-back `start` is accepted then.
- Frame constraint: 4·(DELAY+1) < 100000, enforced by the DELAY range.

## Test plan
- Reset with `start` pulsed at cycle 10 -> no `stra` edge; `busy` stays 1 for exactly RESYNC cycles; all outputs remain at their reset values.
- DELAY=4 with a responder model holding X=+5 (0x05) and Y=-3 (0xFD), buttons pins 5/4 = 0/1 -> `stra` edges at cycles 2/7/12/17; `valid` at cycle 21 with `dx`=0x05, `dy`=0xFD, `btn`=2'b01.
- Two consecutive frames, the second with X=0x80 and Y=0x7F -> `stra` toggles 8 times in total and ends at 0; the second `valid` gives 0x80/0x7F; outputs hold between frames.
- `start` asserted continuously -> frames run back-to-back with exactly one idle cycle between `valid` and the next TOGGLE.
- `start` pulsed during WAIT of nibble 2 -> ignored; exactly four edges and one `valid` result.
- `reset` asserted during nibble 1 -> next cycle `stra`=0, `busy`=1, `dx`/`dy`=0, no `valid`; after RESYNC, a fresh frame reads the correct deltas from nibble 0.

Source files
------------

// File: rtl/msx_mouse_reader.sv
// msx_mouse_reader: host side of the MSX strobe-clocked mouse protocol.
// Issues four strobe edges per frame and rebuilds signed X/Y deltas.
module msx_mouse_reader #(
  parameter int DELAY  = 64,
  parameter int RESYNC = 131072
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] joy_in,
  output logic       stra,
  output logic       busy,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic [1:0] btn,
  output logic       valid
);

  typedef enum logic [2:0] {
    S_RESYNC,
    S_IDLE,
    S_TOGGLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [16:0] RS_LAST = 17'(RESYNC - 1);
  localparam logic [16:0] DL_LAST = 17'(DELAY - 1);

  state_t      r_state;
  state_t      w_next;
  logic [16:0] r_cnt;
  logic [1:0]  r_idx;
  logic [11:0] r_shift;
  logic        r_stra;
  logic [7:0]  r_dx;
  logic [7:0]  r_dy;
  logic [1:0]  r_btn;
  logic        w_zero;
  logic        w_rs_end;

  assign w_zero   = (r_cnt == 17'd0);
  assign w_rs_end = (r_cnt == RS_LAST);

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= S_RESYNC;
    else       r_state <= w_next;
  end

  // Next-state decode and status outputs
  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    valid  = 1'b0;
    unique case (r_state)
      S_RESYNC: begin
        if (w_rs_end) w_next = S_IDLE;
      end
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_TOGGLE;
      end
      S_TOGGLE: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_zero) begin
          if (r_idx == 2'd3) w_next = S_DONE;
          else               w_next = S_TOGGLE;
        end
      end
      S_DONE: begin
        valid  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_RESYNC;
    endcase
  end

  // Counters, strobe, nibble shift register and result registers;
  // results load on the fourth sample so they are visible with valid
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_stra  <= 1'b0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_btn   <= '0;
    end else begin
      unique case (r_state)
        S_RESYNC: begin
          if (!w_rs_end) r_cnt <= r_cnt + 17'd1;
        end
        S_IDLE: begin
          r_idx <= '0;
        end
        S_TOGGLE: begin
          r_stra <= ~r_stra;
          r_cnt  <= DL_LAST;
        end
        S_WAIT: begin
          if (!w_zero) begin
            r_cnt <= r_cnt - 17'd1;
          end else if (r_idx == 2'd3) begin
            r_dx  <= r_shift[11:4];
            r_dy  <= {r_shift[3:0], joy_in[3:0]};
            r_btn <= ~joy_in[5:4];
          end else begin
            r_shift <= {r_shift[7:0], joy_in[3:0]};
            r_idx   <= r_idx + 2'd1;
          end
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign stra = r_stra;
  assign dx   = r_dx;
  assign dy   = r_dy;
  assign btn  = r_btn;

endmodule

// File: tb/tb_msx_mouse_reader.sv
// tb_msx_mouse_reader: directed bench with a small strobe responder.
// DELAY=4 gives strobe edges at cycles 2/7/12/17 and valid at 21.
module tb_msx_mouse_reader;

  localparam int DELAY  = 4;
  localparam int RESYNC = 20;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] joy_in;
  logic       stra;
  logic       busy;
  logic [7:0] dx;
  logic [7:0] dy;
  logic [1:0] btn;
  logic       valid;

  int tests = 0;
  int fails = 0;

  msx_mouse_reader #(
    .DELAY (DELAY),
    .RESYNC(RESYNC)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .start  (start),
    .joy_in (joy_in),
    .stra   (stra),
    .busy   (busy),
    .dx     (dx),
    .dy     (dy),
    .btn    (btn),
    .valid  (valid)
  );

  always #5 clk_sys = ~clk_sys;

  // Responder model: after the k-th strobe edge it drives nibble k-1
  int         edges = 0;
  int         base  = 0;
  logic [3:0] rnib [4];
  logic [1:0] rpins = 2'b11;
  logic [1:0] sel;

  always @(stra) edges = edges + 1;

  assign sel    = 2'(edges - base - 1);
  assign joy_in = {rpins, rnib[sel]};

  task automatic set_resp(input logic [7:0] x, input logic [7:0] y,
                          input logic [1:0] pins);
    rnib[0] = x[7:4];
    rnib[1] = x[3:0];
    rnib[2] = y[7:4];
    rnib[3] = y[3:0];
    rpins   = pins;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int         e_cnt;
  int         v_cnt;
  int         e_cyc [16];
  int         v_cyc [4];
  logic [7:0] v_dx [4];
  logic [7:0] v_dy [4];
  logic [1:0] v_btn [4];
  logic       busy_log [64];

  // Cycle 0 is the cycle in which start is first presented
  task automatic run(input int ncyc, input int hold_last, input int mid);
    logic p;
    p     = stra;
    e_cnt = 0;
    v_cnt = 0;
    start = 1'b1;
    tick();
    for (int c = 1; c <= ncyc; c++) begin
      start = (c <= hold_last) || (c == mid);
      if (stra !== p) begin
        if (e_cnt < 16) e_cyc[e_cnt] = c;
        e_cnt++;
        p = stra;
      end
      if (valid === 1'b1) begin
        if (v_cnt < 4) begin
          v_cyc[v_cnt] = c;
          v_dx[v_cnt]  = dx;
          v_dy[v_cnt]  = dy;
          v_btn[v_cnt] = btn;
        end
        v_cnt++;
      end
      if (c < 64) busy_log[c] = busy;
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    int   n;
    logic bad;

    reset = 1'b1;
    start = 1'b0;
    set_resp(8'h00, 8'h00, 2'b11);
    tick();
    tick();
    tick();
    reset = 1'b0;
    base  = edges;

    // Resync window: start at cycle 10 is dropped, outputs stay reset
    n   = 0;
    bad = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      if (stra !== 1'b0 || valid !== 1'b0 || dx !== 8'h00 ||
          dy !== 8'h00 || btn !== 2'b00) bad = 1'b1;
      start = (n == 10);
      tick();
      n++;
    end
    start = 1'b0;
    chk("resync_len", n, RESYNC);
    chk("resync_outs", {31'd0, bad}, 0);
    tick();
    tick();
    tick();
    chk("no_queued_start", {31'd0, busy}, 0);
    chk("no_reset_edge", {31'd0, stra}, 0);
    chk("reset_edges", edges - base, 0);

    // Frame 1: X=+5, Y=-3, pin5 pressed
    set_resp(8'h05, 8'hFD, 2'b10);
    run(25, 0, -1);
    chk("f1_edges", e_cnt, 4);
    chk("f1_e0", e_cyc[0], 2);
    chk("f1_e1", e_cyc[1], 7);
    chk("f1_e2", e_cyc[2], 12);
    chk("f1_e3", e_cyc[3], 17);
    chk("f1_vcnt", v_cnt, 1);
    chk("f1_vcyc", v_cyc[0], 21);
    chk("f1_dx", v_dx[0], 8'h05);
    chk("f1_dy", v_dy[0], 8'hFD);
    chk("f1_btn", v_btn[0], 2'b01);
    bad = 1'b0;
    for (int c = 1; c <= 21; c++) if (busy_log[c] !== 1'b1) bad = 1'b1;
    chk("f1_busy_hi", {31'd0, bad}, 0);
    chk("f1_busy_lo", {31'd0, busy_log[22]}, 0);

    // Hold between frames
    tick();
    tick();
    chk("hold_dx", dx, 8'h05);
    chk("hold_dy", dy, 8'hFD);
    chk("hold_btn", btn, 2'b01);

    // Frame 2: extreme values, buttons released
    set_resp(8'h80, 8'h7F, 2'b11);
    run(25, 0, -1);
    chk("f2_edges", e_cnt, 4);
    chk("f2_vcnt", v_cnt, 1);
    chk("f2_dx", v_dx[0], 8'h80);
    chk("f2_dy", v_dy[0], 8'h7F);
    chk("f2_btn", v_btn[0], 2'b00);
    chk("f2_stra_end", {31'd0, stra}, 0);
    chk("f2_total_edges", edges - base, 8);

    // Continuous start: second TOGGLE in cycle 23
    set_resp(8'h61, 8'h9E, 2'b00);
    run(46, 22, -1);
    chk("bb_edges", e_cnt, 8);
    chk("bb_e4", e_cyc[4], 24);
    chk("bb_vcnt", v_cnt, 2);
    chk("bb_v0", v_cyc[0], 21);
    chk("bb_v1", v_cyc[1], 43);
    chk("bb_dx", v_dx[1], 8'h61);
    chk("bb_dy", v_dy[1], 8'h9E);
    chk("bb_btn", v_btn[1], 2'b11);

    // Start during WAIT of nibble index 2 is dropped
    set_resp(8'h12, 8'h34, 2'b01);
    run(30, 0, 13);
    chk("mid_edges", e_cnt, 4);
    chk("mid_vcnt", v_cnt, 1);
    chk("mid_dx", v_dx[0], 8'h12);
    chk("mid_dy", v_dy[0], 8'h34);
    chk("mid_btn", v_btn[0], 2'b10);

    // Reset while the first nibble is being settled
    set_resp(8'hA7, 8'h3C, 2'b11);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_pre_stra", {31'd0, stra}, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_stra", {31'd0, stra}, 0);
    chk("rst_busy", {31'd0, busy}, 1);
    chk("rst_dx", dx, 8'h00);
    chk("rst_dy", dy, 8'h00);
    chk("rst_btn", btn, 2'b00);
    n   = 0;
    bad = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      if (valid !== 1'b0 || stra !== 1'b0) bad = 1'b1;
      tick();
      n++;
    end
    chk("rst_resync_len", n, RESYNC);
    chk("rst_no_valid", {31'd0, bad}, 0);
    base = edges;

    run(25, 0, -1);
    chk("rf_edges", e_cnt, 4);
    chk("rf_e0", e_cyc[0], 2);
    chk("rf_vcnt", v_cnt, 1);
    chk("rf_dx", v_dx[0], 8'hA7);
    chk("rf_dy", v_dy[0], 8'h3C);
    chk("rf_btn", v_btn[0], 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
